button_ctrl: RTL and testbench

//  Front-end for counter_top: turns two raw push-button inputs into clean enable/dir controls.
//  Per button: 2-FF synchroniser, counter debouncer, press (rising) detection.
//  Run/direction FSM drives counter_top.enable and counter_top.dir.

---
 rtl/button_ctrl.sv | 136 +++++++++++++
 tb/tb_button_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_ctrl.sv
// Push-button front-end for counter_top: synchronises and debounces two raw buttons,
// detects presses, and runs the run/direction FSM that drives enable and dir.
module button_ctrl #(
  parameter int unsigned DEBOUNCE  = 16,
  parameter int unsigned FLIP_HOLD = 4,
  parameter bit          DIR_INIT  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_dir,
  output logic enable,
  output logic dir,
  output logic run_press,
  output logic dir_press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE);
  localparam int unsigned HcW  = (FLIP_HOLD > 1) ? $clog2(FLIP_HOLD) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);
  localparam logic [HcW-1:0]  HcMax  = HcW'(FLIP_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlip} state_e;

  // Bit 0 is the run button, bit 1 the direction button.
  logic [1:0]           btn;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           db_q, db_d;
  logic [1:0][CntW-1:0] cnt_q, cnt_d;
  logic [1:0]           rise;
  logic [1:0]           press_q;

  state_e         state_q, state_d;
  logic [HcW-1:0] hc_q, hc_d;
  logic           enable_q, enable_d;
  logic           dir_q, dir_d;

  assign btn = {btn_dir, btn_run};

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    rise  = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          db_d[i] = sync2_q[i];
          rise[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
      press_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= rise;
    end
  end

  // A run press always takes priority over a direction press or hold expiry.
  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    enable_d = enable_q;
    dir_d    = dir_q;
    unique case (state_q)
      StIdle: begin
        if (rise[0]) begin
          state_d  = StRun;
          enable_d = 1'b1;
        end else if (rise[1]) begin
          dir_d = ~dir_q;
        end
      end
      StRun: begin
        if (rise[0]) begin
          state_d  = StIdle;
          enable_d = 1'b0;
        end else if (rise[1]) begin
          state_d  = StFlip;
          hc_d     = '0;
          enable_d = 1'b0;
        end
      end
      StFlip: begin
        if (rise[0]) begin
          state_d  = StIdle;
          dir_d    = ~dir_q;
          enable_d = 1'b0;
        end else if (hc_q == HcMax) begin
          state_d  = StRun;
          dir_d    = ~dir_q;
          enable_d = 1'b1;
        end else begin
          hc_d = hc_q + HcW'(1);
        end
      end
      default: begin
        state_d  = StIdle;
        enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      hc_q     <= '0;
      enable_q <= 1'b0;
      dir_q    <= DIR_INIT;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      enable_q <= enable_d;
      dir_q    <= dir_d;
    end
  end

  assign enable    = enable_q;
  assign dir       = dir_q;
  assign run_press = press_q[0];
  assign dir_press = press_q[1];

endmodule

// File: tb/tb_button_ctrl.sv
// Bench for button_ctrl: directed scenarios plus randomized button traffic checked
// against a window-based behavioural model of debounce and run/flip control.
module tb_button_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned FH  = 2;
  localparam int unsigned HL  = DEB + 1;

  logic clk = 1'b0;
  logic reset, btn_run, btn_dir;
  logic enable, dir, run_press, dir_press;

  int checks = 0;
  int errors = 0;

  button_ctrl #(
    .DEBOUNCE (DEB),
    .FLIP_HOLD(FH),
    .DIR_INIT (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_run  (btn_run),
    .btn_dir  (btn_dir),
    .enable   (enable),
    .dir      (dir),
    .run_press(run_press),
    .dir_press(dir_press)
  );

  always #5 clk = ~clk;

  // Reference model. hist bit 0 holds the raw sample from the previous edge; a debounced
  // level flips when the DEB samples seen two or more edges ago all disagree with it.
  typedef enum int {MIdle, MRun, MFlip} mode_e;
  logic [HL-1:0] hist_r, hist_d;
  logic          mdb_r, mdb_d;
  logic          chg_r, chg_d, m_rp, m_dp;
  logic          e_en, e_dir, e_rp, e_dp;
  mode_e         m_mode;
  int            m_left;

  function automatic logic win_hit(input logic [HL-1:0] h, input logic db);
    for (int i = 1; i <= int'(DEB); i++) if (h[i] == db) return 1'b0;
    return 1'b1;
  endfunction

  assign chg_r = win_hit(hist_r, mdb_r);
  assign chg_d = win_hit(hist_d, mdb_d);
  assign m_rp  = chg_r && !mdb_r;
  assign m_dp  = chg_d && !mdb_d;

  always @(posedge clk) begin
    if (reset) begin
      hist_r <= '0;
      hist_d <= '0;
      mdb_r  <= 1'b0;
      mdb_d  <= 1'b0;
      m_mode <= MIdle;
      m_left <= 0;
      e_en   <= 1'b0;
      e_dir  <= 1'b1;
      e_rp   <= 1'b0;
      e_dp   <= 1'b0;
    end else begin
      hist_r <= {hist_r[HL-2:0], btn_run};
      hist_d <= {hist_d[HL-2:0], btn_dir};
      if (chg_r) mdb_r <= ~mdb_r;
      if (chg_d) mdb_d <= ~mdb_d;
      e_rp <= m_rp;
      e_dp <= m_dp;
      if (m_rp) begin
        case (m_mode)
          MIdle:   begin m_mode <= MRun;  e_en <= 1'b1; end
          MRun:    begin m_mode <= MIdle; e_en <= 1'b0; end
          default: begin m_mode <= MIdle; e_en <= 1'b0; e_dir <= ~e_dir; end
        endcase
      end else if (m_mode == MFlip) begin
        if (m_left == 1) begin
          m_mode <= MRun;
          e_en   <= 1'b1;
          e_dir  <= ~e_dir;
        end
        m_left <= m_left - 1;
      end else if (m_dp) begin
        if (m_mode == MIdle) begin
          e_dir <= ~e_dir;
        end else begin
          m_mode <= MFlip;
          m_left <= int'(FH);
          e_en   <= 1'b0;
        end
      end
    end
  end

  task automatic press(input bit which);
    if (which) btn_dir = 1'b1; else btn_run = 1'b1;
    repeat (DEB + 4) @(negedge clk);
    btn_run = 1'b0;
    btn_dir = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_run = 1'b0; btn_dir = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({enable, dir, run_press, dir_press} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_values: got %b want 0100", {enable, dir, run_press, dir_press});
    end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({enable, dir, run_press, dir_press} !== 4'b0100) begin
        errors++;
        $display("FAIL reset_quiet cycle %0d: got %b want 0100", i,
                 {enable, dir, run_press, dir_press});
      end
    end
  endtask

  task automatic test_bounce_press();
    logic exp;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (run_press !== 1'b0 || enable !== 1'b0) begin
        errors++;
        $display("FAIL bounce_quiet cycle %0d: got rp=%b en=%b want 0 0", i, run_press, enable);
      end
      btn_run = (i % 2 == 0);
    end
    @(negedge clk);
    btn_run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      exp = (i == 5);
      checks++;
      if (run_press !== exp) begin
        errors++;
        $display("FAIL bounce_pulse edge k+%0d: got %b want %b", i, run_press, exp);
      end
      checks++;
      if (enable !== (i >= 5)) begin
        errors++;
        $display("FAIL bounce_enable edge k+%0d: got %b want %b", i, enable, (i >= 5));
      end
    end
    btn_run = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (enable !== 1'b1 || run_press !== 1'b0) begin
        errors++;
        $display("FAIL release_no_action cycle %0d: got en=%b rp=%b want 1 0", i, enable,
                 run_press);
      end
    end
  endtask

  task automatic test_glitch();
    btn_run = 1'b1;
    repeat (3) @(negedge clk);
    btn_run = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (enable !== 1'b1 || run_press !== 1'b0) begin
        errors++;
        $display("FAIL glitch cycle %0d: got en=%b rp=%b want 1 0", i, enable, run_press);
      end
    end
  endtask

  task automatic test_flip();
    logic exp_en, exp_dir;
    btn_dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_en  = (i < 5) || (i >= 7);
      exp_dir = (i < 7);
      checks++;
      if (enable !== exp_en || dir !== exp_dir || dir_press !== (i == 5)) begin
        errors++;
        $display("FAIL flip edge k+%0d: got en=%b dir=%b dp=%b want %b %b %b", i, enable, dir,
                 dir_press, exp_en, exp_dir, (i == 5));
      end
    end
    btn_dir = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (enable !== 1'b1 || dir !== 1'b0) begin
      errors++;
      $display("FAIL flip_settle: got en=%b dir=%b want 1 0", enable, dir);
    end
  endtask

  task automatic test_idle_dir();
    press(1'b0);
    btn_dir = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (enable !== 1'b0 || dir !== (i >= 5) || dir_press !== (i == 5)) begin
        errors++;
        $display("FAIL idle_dir edge k+%0d: got en=%b dir=%b dp=%b want 0 %b %b", i, enable,
                 dir, dir_press, (i >= 5), (i == 5));
      end
    end
    btn_dir = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    btn_run = 1'b1;
    btn_dir = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (run_press !== (i == 5) || dir_press !== (i == 5) || enable !== (i >= 5) ||
          dir !== 1'b1) begin
        errors++;
        $display("FAIL simultaneous edge k+%0d: got rp=%b dp=%b en=%b dir=%b want %b %b %b 1",
                 i, run_press, dir_press, enable, dir, (i == 5), (i == 5), (i >= 5));
      end
    end
    btn_run = 1'b0;
    btn_dir = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_in_flip();
    press(1'b0);
    press(1'b1);
    press(1'b0);
    btn_dir = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (enable !== 1'b0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL flip_entry: got en=%b dir=%b want 0 0", enable, dir);
    end
    reset   = 1'b1;
    btn_run = 1'b1;
    btn_dir = 1'b0;
    @(negedge clk);
    checks++;
    if ({enable, dir, run_press, dir_press} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_in_flip: got %b want 0100", {enable, dir, run_press, dir_press});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      checks++;
      if (run_press !== (i == 6) || enable !== (i >= 6)) begin
        errors++;
        $display("FAIL held_through_reset edge %0d: got rp=%b en=%b want %b %b", i, run_press,
                 enable, (i == 6), (i >= 6));
      end
    end
    btn_run = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    int run_left = 0;
    int dir_left = 0;
    int rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if ({enable, dir, run_press, dir_press} !== {e_en, e_dir, e_rp, e_dp}) begin
        errors++;
        $display("FAIL random cycle %0d: got en/dir/rp/dp=%b want %b", c,
                 {enable, dir, run_press, dir_press}, {e_en, e_dir, e_rp, e_dp});
      end
      if (run_left == 0) begin
        btn_run  = 1'($urandom_range(0, 1));
        run_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 14));
      end
      run_left--;
      if (dir_left == 0) begin
        btn_dir  = 1'($urandom_range(0, 1));
        dir_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 14));
      end
      dir_left--;
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 499) == 0) rst_left = int'($urandom_range(1, 3));
      reset = (rst_left > 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce_press();
    test_glitch();
    test_flip();
    test_idle_dir();
    test_simultaneous();
    test_reset_in_flip();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
